mem_access_ctrl: RTL and testbench

- Sequences every transaction on the CPU's single Avalon-style memory master port, sharing it between the instruction-fetch path and the load/store path.
- Enforces the waitrequest handshake.
- Produces a one-cycle load strobe and data word for the instruction register, and a read-return strobe for the data path.
- Sits between the control FSM/datapath and the external memory bus.

---
 rtl/mips_bus_pkg.sv | 22 ++
 rtl/bus_timeout_counter.sv | 36 +++
 rtl/mem_access_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the CPU memory bus controller.
//   state_e          : controller FSM states
//   BE_WORD          : full-word byte enable pattern
//   TIMEOUT_DEFAULT  : default stall limit before a transaction is aborted
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [3:0]  BE_WORD         = 4'hF;
  localparam int unsigned TIMEOUT_DEFAULT = 255;

  // A word transfer must start on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Stall counter for one bus transaction.
//   clk, reset : clock, async active-low reset
//   clear      : zero the count (asserted while no transaction is on the bus)
//   enable     : a stalled bus cycle (strobe high, waitrequest high)
//   expired_c  : this stalled cycle is the LIMIT-th in a row; abort now
module bus_timeout_counter
  import mips_bus_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned CNT_W = ($clog2(LIMIT + 1) > 8) ? $clog2(LIMIT + 1) : 8;

  logic [CNT_W-1:0] count;

  // Saturating count of consecutive stalled cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CNT_W'(LIMIT))) begin
      count <= count + CNT_W'(1);
    end
  end

  // Count already holds LIMIT-1 stalls, so this stall is the LIMIT-th.
  assign expired_c = enable && (count >= CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Shares the single Avalon-style memory master between instruction fetch and
// load/store, enforcing waitrequest and producing completion strobes.
//   clk, reset           : clock, async active-low reset
//   fetch_req/fetch_addr : instruction fetch request (level, held until fetch_done)
//   data_req/data_we/... : load/store request (level, held until data_done)
//   avm_*                : memory bus master (all outputs registered)
//   ir_load/ir_data      : one-cycle instruction register load and its word
//   fetch_done/data_done : one-cycle completion strobes
//   data_rdata           : captured load data
//   bus_err              : one-cycle timeout or misalignment error
//   busy                 : controller not in IDLE
module mem_access_ctrl
  import mips_bus_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  input  logic [3:0]        data_byteen,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  output logic              ir_load,
  output logic [31:0]       ir_data,
  output logic              fetch_done,
  output logic [31:0]       data_rdata,
  output logic              data_done,
  output logic              bus_err,
  output logic              busy
);

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] address_nxt;
  logic              read_nxt, write_nxt;
  logic [31:0]       writedata_nxt;
  logic [3:0]        byteenable_nxt;
  logic [31:0]       ir_data_nxt, data_rdata_nxt;
  logic              ir_load_nxt, fetch_done_nxt, data_done_nxt, bus_err_nxt;
  logic              busy_nxt;
  logic              on_bus_c;
  logic              expired_c;

  assign on_bus_c = (state == FETCH) || (state == DATA);

  bus_timeout_counter #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .clear     (!on_bus_c),
    .enable    (on_bus_c && avm_waitrequest),
    .expired_c (expired_c)
  );

  // Next-state and next-output logic; bus fields hold unless a grant loads them.
  always_comb begin
    state_nxt      = state;
    address_nxt    = avm_address;
    read_nxt       = avm_read;
    write_nxt      = avm_write;
    writedata_nxt  = avm_writedata;
    byteenable_nxt = avm_byteenable;
    ir_data_nxt    = ir_data;
    data_rdata_nxt = data_rdata;
    ir_load_nxt    = 1'b0;
    fetch_done_nxt = 1'b0;
    data_done_nxt  = 1'b0;
    bus_err_nxt    = 1'b0;

    unique case (state)
      IDLE: begin
        if (data_req) begin
          if (is_misaligned(data_addr[1:0])) begin
            state_nxt     = RESP;
            data_done_nxt = 1'b1;
            bus_err_nxt   = 1'b1;
          end else begin
            state_nxt      = DATA;
            address_nxt    = data_addr;
            writedata_nxt  = data_wdata;
            byteenable_nxt = data_byteen;
            read_nxt       = !data_we;
            write_nxt      = data_we;
          end
        end else if (fetch_req) begin
          if (is_misaligned(fetch_addr[1:0])) begin
            state_nxt      = RESP;
            fetch_done_nxt = 1'b1;
            bus_err_nxt    = 1'b1;
          end else begin
            state_nxt      = FETCH;
            address_nxt    = fetch_addr;
            byteenable_nxt = BE_WORD;
            read_nxt       = 1'b1;
          end
        end
      end

      FETCH: begin
        if (!avm_waitrequest) begin
          state_nxt      = RESP;
          read_nxt       = 1'b0;
          ir_data_nxt    = avm_readdata;
          ir_load_nxt    = 1'b1;
          fetch_done_nxt = 1'b1;
        end else if (expired_c) begin
          state_nxt      = RESP;
          read_nxt       = 1'b0;
          fetch_done_nxt = 1'b1;
          bus_err_nxt    = 1'b1;
        end
      end

      DATA: begin
        if (!avm_waitrequest) begin
          state_nxt     = RESP;
          read_nxt      = 1'b0;
          write_nxt     = 1'b0;
          data_done_nxt = 1'b1;
          if (avm_read) begin
            data_rdata_nxt = avm_readdata;
          end
        end else if (expired_c) begin
          state_nxt     = RESP;
          read_nxt      = 1'b0;
          write_nxt     = 1'b0;
          data_done_nxt = 1'b1;
          bus_err_nxt   = 1'b1;
        end
      end

      RESP: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
        read_nxt  = 1'b0;
        write_nxt = 1'b0;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      avm_address    <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_writedata  <= '0;
      avm_byteenable <= '0;
      ir_data        <= '0;
      data_rdata     <= '0;
      ir_load        <= 1'b0;
      fetch_done     <= 1'b0;
      data_done      <= 1'b0;
      bus_err        <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_nxt;
      avm_address    <= address_nxt;
      avm_read       <= read_nxt;
      avm_write      <= write_nxt;
      avm_writedata  <= writedata_nxt;
      avm_byteenable <= byteenable_nxt;
      ir_data        <= ir_data_nxt;
      data_rdata     <= data_rdata_nxt;
      ir_load        <= ir_load_nxt;
      fetch_done     <= fetch_done_nxt;
      data_done      <= data_done_nxt;
      bus_err        <= bus_err_nxt;
      busy           <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl (TIMEOUT = 4).
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_byteen;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        ir_load;
  logic [31:0] ir_data;
  logic        fetch_done;
  logic [31:0] data_rdata;
  logic        data_done;
  logic        bus_err;
  logic        busy;

  mem_access_ctrl #(
    .ADDR_W  (32),
    .TIMEOUT (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_req       (fetch_req),
    .fetch_addr      (fetch_addr),
    .data_req        (data_req),
    .data_we         (data_we),
    .data_addr       (data_addr),
    .data_wdata      (data_wdata),
    .data_byteen     (data_byteen),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_byteenable  (avm_byteenable),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .ir_load         (ir_load),
    .ir_data         (ir_data),
    .fetch_done      (fetch_done),
    .data_rdata      (data_rdata),
    .data_done       (data_done),
    .bus_err         (bus_err),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Per-test observation record, cycle 0 is the negedge where requests rise.
  int          cyc;
  int          wait_left;
  logic        stuck;
  int          rd_cycles, wr_cycles, addr_bad;
  int          ir_loads, fetch_dones, data_dones, bus_errs;
  int          first_rd_cyc, first_wr_cyc;
  int          ir_load_cyc, fetch_done_cyc, data_done_cyc, bus_err_cyc;
  logic [31:0] exp_addr;
  logic [31:0] rd_addr, wr_addr, wr_data;
  logic [3:0]  rd_be, wr_be;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    cyc = 0; wait_left = 0; stuck = 1'b0;
    rd_cycles = 0; wr_cycles = 0; addr_bad = 0;
    ir_loads = 0; fetch_dones = 0; data_dones = 0; bus_errs = 0;
    first_rd_cyc = -1; first_wr_cyc = -1;
    ir_load_cyc = -1; fetch_done_cyc = -1; data_done_cyc = -1; bus_err_cyc = -1;
    exp_addr = '0;
  endtask

  // Advance one cycle, sample outputs at the negedge, then act as bus slave
  // and requester for the following rising edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (avm_read) begin
      rd_cycles++;
      if (first_rd_cyc < 0) begin
        first_rd_cyc = cyc; rd_addr = avm_address; rd_be = avm_byteenable;
      end
    end
    if (avm_write) begin
      wr_cycles++;
      if (first_wr_cyc < 0) begin
        first_wr_cyc = cyc; wr_addr = avm_address; wr_data = avm_writedata; wr_be = avm_byteenable;
      end
    end
    if ((avm_read || avm_write) && (avm_address !== exp_addr)) addr_bad++;
    if (ir_load)    begin ir_loads++;    ir_load_cyc = cyc;    end
    if (fetch_done) begin fetch_dones++; fetch_done_cyc = cyc; fetch_req = 1'b0; end
    if (data_done)  begin data_dones++;  data_done_cyc = cyc;  data_req = 1'b0;  end
    if (bus_err)    begin bus_errs++;    bus_err_cyc = cyc;    end
    avm_waitrequest = 1'b0;
    if (avm_read || avm_write) begin
      if (stuck) begin
        avm_waitrequest = 1'b1;
      end else if (wait_left > 0) begin
        avm_waitrequest = 1'b1;
        wait_left--;
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    fetch_req = 1'b0; fetch_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0; data_byteen = '0;
    avm_readdata = '0; avm_waitrequest = 1'b0;
    clear_stats();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_strobes", 32'({avm_read, avm_write, ir_load, fetch_done, data_done, bus_err, busy}), 32'd0);
    check("rst_ir_data", ir_data, 32'd0);
    check("rst_data_rdata", data_rdata, 32'd0);
    check("rst_bus_fields", avm_address | avm_writedata | 32'(avm_byteenable), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Fetch, zero wait
    clear_stats();
    fetch_addr = 32'h0000_0010; exp_addr = 32'h0000_0010; avm_readdata = 32'h8C22_0004;
    fetch_req = 1'b1;
    repeat (8) step();
    check("f0_rd_cycles", 32'(rd_cycles), 32'd1);
    check("f0_addr", rd_addr, 32'h0000_0010);
    check("f0_be", 32'(rd_be), 32'hF);
    check("f0_ir_load_cyc", 32'(ir_load_cyc), 32'd2);
    check("f0_done_cyc", 32'(fetch_done_cyc), 32'd2);
    check("f0_ir_loads", 32'(ir_loads), 32'd1);
    check("f0_ir_data", ir_data, 32'h8C22_0004);
    check("f0_bus_err", 32'(bus_errs), 32'd0);

    // Fetch, 3 wait cycles
    clear_stats();
    fetch_addr = 32'h0000_0014; exp_addr = 32'h0000_0014; avm_readdata = 32'h1234_5678;
    wait_left = 3;
    fetch_req = 1'b1;
    repeat (10) step();
    check("f3_rd_cycles", 32'(rd_cycles), 32'd4);
    check("f3_addr_stable", 32'(addr_bad), 32'd0);
    check("f3_ir_load_cyc", 32'(ir_load_cyc), 32'd5);
    check("f3_ir_loads", 32'(ir_loads), 32'd1);
    check("f3_ir_data", ir_data, 32'h1234_5678);

    // Simultaneous fetch and store: store wins
    clear_stats();
    fetch_addr = 32'h0000_0018; avm_readdata = 32'hCAFE_F00D;
    data_we = 1'b1; data_addr = 32'h0000_0020; data_wdata = 32'hDEAD_BEEF; data_byteen = 4'b0011;
    exp_addr = 32'h0000_0020;
    fetch_req = 1'b1; data_req = 1'b1;
    repeat (10) step();
    check("sim_first_wr_cyc", 32'(first_wr_cyc), 32'd1);
    check("sim_wr_cycles", 32'(wr_cycles), 32'd1);
    check("sim_wr_addr", wr_addr, 32'h0000_0020);
    check("sim_wr_data", wr_data, 32'hDEAD_BEEF);
    check("sim_wr_be", 32'(wr_be), 32'h3);
    check("sim_data_done_cyc", 32'(data_done_cyc), 32'd2);
    check("sim_first_rd_cyc", 32'(first_rd_cyc), 32'd4);
    check("sim_rd_addr", rd_addr, 32'h0000_0018);
    check("sim_fetch_done_cyc", 32'(fetch_done_cyc), 32'd5);
    check("sim_ir_data", ir_data, 32'hCAFE_F00D);
    check("sim_data_rdata_held", data_rdata, 32'd0);

    // Aligned load with one wait cycle
    clear_stats();
    data_we = 1'b0; data_addr = 32'h0000_0040; data_byteen = 4'hF;
    exp_addr = 32'h0000_0040; avm_readdata = 32'hA5A5_0001; wait_left = 1;
    data_req = 1'b1;
    repeat (8) step();
    check("ld_rd_cycles", 32'(rd_cycles), 32'd2);
    check("ld_wr_cycles", 32'(wr_cycles), 32'd0);
    check("ld_done_cyc", 32'(data_done_cyc), 32'd3);
    check("ld_data_rdata", data_rdata, 32'hA5A5_0001);
    check("ld_ir_held", ir_data, 32'hCAFE_F00D);
    check("ld_no_ir_load", 32'(ir_loads), 32'd0);

    // Misaligned load
    clear_stats();
    data_we = 1'b0; data_addr = 32'h0000_0006; data_byteen = 4'hF; avm_readdata = 32'h7777_7777;
    data_req = 1'b1;
    repeat (6) step();
    check("mis_no_bus", 32'(rd_cycles + wr_cycles), 32'd0);
    check("mis_bus_errs", 32'(bus_errs), 32'd1);
    check("mis_data_dones", 32'(data_dones), 32'd1);
    check("mis_err_cyc", 32'(bus_err_cyc), 32'd1);
    check("mis_done_cyc", 32'(data_done_cyc), 32'd1);
    check("mis_rdata_held", data_rdata, 32'hA5A5_0001);

    // Timeout on a stuck fetch
    clear_stats();
    fetch_addr = 32'h0000_0050; exp_addr = 32'h0000_0050; avm_readdata = 32'h5555_AAAA;
    stuck = 1'b1;
    fetch_req = 1'b1;
    repeat (10) step();
    check("to_rd_cycles", 32'(rd_cycles), 32'd4);
    check("to_bus_errs", 32'(bus_errs), 32'd1);
    check("to_fetch_dones", 32'(fetch_dones), 32'd1);
    check("to_done_cyc", 32'(fetch_done_cyc), 32'd5);
    check("to_err_with_done", 32'(bus_err_cyc), 32'd5);
    check("to_no_ir_load", 32'(ir_loads), 32'd0);
    check("to_ir_held", ir_data, 32'hCAFE_F00D);

    // Reset in the middle of a stalled fetch
    clear_stats();
    fetch_addr = 32'h0000_0060; exp_addr = 32'h0000_0060; stuck = 1'b1;
    fetch_req = 1'b1;
    repeat (2) step();
    check("mr_read_before", 32'(avm_read), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mr_read_async", 32'(avm_read), 32'd0);
    check("mr_busy_async", 32'(busy), 32'd0);
    fetch_req = 1'b0; stuck = 1'b0; avm_waitrequest = 1'b0;
    @(negedge clk);
    check("mr_no_ir_load", 32'({ir_load, fetch_done}), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("mr_busy_after", 32'(busy), 32'd0);
    clear_stats();
    fetch_addr = 32'h0000_0064; exp_addr = 32'h0000_0064; avm_readdata = 32'h0BAD_F00D;
    fetch_req = 1'b1;
    repeat (8) step();
    check("mr_refetch_cyc", 32'(ir_load_cyc), 32'd2);
    check("mr_refetch_loads", 32'(ir_loads), 32'd1);
    check("mr_refetch_data", ir_data, 32'h0BAD_F00D);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
